// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between the instruction and data cache ports; optional ARB_ROUND_ROBIN_EN fairness.
// Latency: grant at N, strobes at N+1, wait low the cycle after ram_ready (minimum N+2); watchdog aborts after TIMEOUT strobe cycles.
// Backpressure: one transaction in flight; requesters hold iREN/dREN/dWEN until their wait pulses low, re-sampled only in IDLE.
module memory_arbiter #(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        err
);

    localparam int             CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISERV,
        DSERV,
        IRESP,
        DRESP
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   wdog_cnt;
    logic            wr_q;
    logic            d_pend;
    logic            grant_i;
    logic            grant_d;
    logic            svc_done;
    logic            svc_abort;
    logic            in_serv;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data side was granted last
    logic            last_grant_d;
`endif

    assign d_pend  = dREN | dWEN;
    assign in_serv = (state == ISERV) || (state == DSERV);

    // Outputs are pure decodes of registered state; no requester input reaches them.
    assign ramREN = (state == ISERV) || ((state == DSERV) && !wr_q);
    assign ramWEN = (state == DSERV) && wr_q;
    assign iwait  = (state != IRESP);
    assign dwait  = (state != DRESP);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        svc_done   = 1'b0;
        svc_abort  = 1'b0;
        case (state)
            IDLE: begin
                if (d_pend && iREN) begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (last_grant_d) begin
                        grant_i = 1'b1;
                    end else begin
                        grant_d = 1'b1;
                    end
`else
                    grant_d = 1'b1;
`endif
                end else if (d_pend) begin
                    grant_d = 1'b1;
                end else if (iREN) begin
                    grant_i = 1'b1;
                end
                if (grant_i) begin
                    next_state = ISERV;
                end else if (grant_d) begin
                    next_state = DSERV;
                end
            end
            ISERV, DSERV: begin
                if (ram_ready) begin
                    svc_done   = 1'b1;
                    next_state = (state == ISERV) ? IRESP : DRESP;
                end else if (wdog_cnt == CNT_MAX) begin
                    svc_abort  = 1'b1;
                    next_state = (state == ISERV) ? IRESP : DRESP;
                end
            end
            IRESP, DRESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wdog_cnt <= '0;
            wr_q     <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            iload    <= '0;
            dload    <= '0;
            err      <= 1'b0;
        end else begin
            if (grant_i || grant_d) begin
                wdog_cnt <= '0;
                ramaddr  <= grant_d ? daddr : iaddr;
                // Write wins when the data side asserts both strobes.
                wr_q     <= grant_d & dWEN;
                if (grant_d) begin
                    ramstore <= dstore;
                end
            end else if (in_serv) begin
                wdog_cnt <= wdog_cnt + CW'(1);
            end

            if (state == ISERV) begin
                if (svc_done) begin
                    iload <= ramload;
                end else if (svc_abort) begin
                    iload <= ERR_WORD;
                end
            end

            // A timed-out write also reports ERR_WORD so software sees the failure.
            if (state == DSERV) begin
                if (svc_done && !wr_q) begin
                    dload <= ramload;
                end else if (svc_abort) begin
                    dload <= ERR_WORD;
                end
            end

            if (svc_abort) begin
                err <= 1'b1;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_grant_d <= 1'b0;
        end else if (grant_i || grant_d) begin
            last_grant_d <= grant_d;
        end
    end
`endif

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Single-port memory controller between the instruction/data cache request ports and the one shared RAM. Accepts one outstanding request at a time from the instruction side (iREN) or the data side (dREN/dWEN), sequences the RAM handshake, and returns load data with a one-cycle wait release. Includes a RAM watchdog. It is the block that drives the `cif` side of the cache wrapper.

## Interface
Parameters:
- TIMEOUT, 64: max cycles in a service state without ram_ready before abort; ≥2.
- ERR_WORD, 32'hBAD1BAD1: load value returned on timeout.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- iREN  in  1  instruction read request; held until iwait low.
- iaddr  in  32  instruction address.
- dREN  in  1  data read request; held until dwait low.
- dWEN  in  1  data write request; held until dwait low.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- iwait  out  1  low for exactly one cycle when the instruction request completes.
- dwait  out  1  low for exactly one cycle when the data request completes.
- iload  out  32  registered instruction word, valid while iwait low.
- dload  out  32  registered data word, valid while dwait low after a read.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, valid with ram_ready.
- ram_ready  in  1  RAM completion, single cycle.
- err  out  1  sticky timeout flag; cleared only by RST.

## Operation
- States: IDLE, ISERV, DSERV, IRESP, DRESP.
- IDLE: evaluate requests. Data pending (dREN|dWEN) and instr pending: grant per arbitration policy (Configuration). Only one pending: grant it. Nothing pending: stay.
- At grant, register address, store data and write flag (dWEN wins if dREN&dWEN) into ramaddr/ramstore. Clear the watchdog counter. Enter ISERV/DSERV.
- ISERV/DSERV: ramREN=1 (or ramWEN=1 for data write). ramREN and ramWEN are never both 1. Watchdog increments each cycle.
- On ram_ready: capture ramload into iload (ISERV) or dload (DSERV read; dload unchanged on write). Go to IRESP/DRESP.
- Counter reaches TIMEOUT-1 without ram_ready: load ERR_WORD into the target register, set err. Go to IRESP/DRESP.
- IRESP/DRESP: strobes deasserted, matching wait=0 for one cycle. Next state is IDLE.
- Request dropped mid-service: the transaction still completes and the wait pulse is still issued. The requester ignores it.
- No new grant in RESP states. Requests are re-sampled in IDLE only.

## Timing
- Reset values: state IDLE, iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, err=0, last_grant=instr.
- All outputs are registered or decoded from state only. There is no combinational path from requester inputs to any output.
- Request sampled in IDLE at cycle N → strobes high at N+1.
- ram_ready at cycle M → wait low at M+1 → IDLE at M+2.
- Minimum request-to-completion: wait low at N+2. Back-to-back grant earliest at the cycle after RESP.
- Timeout: strobes held TIMEOUT cycles, then wait low next cycle.
- RST mid-transaction: immediate return to reset values; the in-flight RAM access is abandoned.
- ram_ready in IDLE/RESP: ignored.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a simultaneous instr+data request, grant the side not in last_grant; last_grant updates at every grant.
- ARB_ROUND_ROBIN_EN undefined: data always wins. last_grant is not implemented.

## Test plan
- Single instr read, iaddr=0x40, ram_ready 3 cycles after strobe, ramload=0x8C220004 → ramREN 1 for 3 cycles, iwait low one cycle, iload=0x8C220004.
- Data write daddr=0x100, dstore=0xDEADBEEF, ramready first cycle → ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF, dwait low at N+2, dload unchanged.
- iREN+dREN held together for 4 transactions, ram_ready immediate → undefined macro: D,D,D,D with instr starved; defined: D,I,D,I.
- No ram_ready, TIMEOUT=8, dREN → ramREN high 8 cycles, dload=0xBAD1BAD1, dwait low once, err=1 stays 1 until RST.
- RST pulse while in DSERV with ramREN=1 → same-cycle async return: ramREN=0, dwait=1, state IDLE; pending dREN is re-granted after release.
- dREN&dWEN both high → write only: ramWEN=1, ramREN=0.
